// File: rtl/pipelined_addsub_unit.sv
// Carry-pipelined N-bit add/subtract unit with bypass and saturating add.
// One CHUNK-bit ripple slice per stage; the carry and the partial sum ride along with the beat.
module pipelined_addsub_unit #(
  parameter int N     = 16,
  parameter int CHUNK = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   op,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         ci,
  input  logic [N-1:0] X,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out,
  output logic         co,
  output logic         ovf
);

  localparam int L = N / CHUNK;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_PASS = 2'b10;
  localparam logic [1:0] OP_SAT  = 2'b11;

  if (N % CHUNK != 0) begin : g_bad_chunk
    $error("pipelined_addsub_unit: N must be a multiple of CHUNK");
  end

  // Handshake: a beat moves on an edge where valid && ready. A result held with
  // out_ready low freezes the whole pipeline, and in_ready drops in that same cycle.
  logic stall;
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  // Stage k holds the beat before slice k is added; r_q holds slices already resolved.
  logic         vld_q [L];
  logic [1:0]   op_q  [L];
  logic [N-1:0] x_q   [L];
  logic [N-1:0] a_q   [L];
  logic [N-1:0] b_q   [L];
  logic         c_q   [L];
  logic [N-1:0] r_q   [L];

  logic [CHUNK:0] slice_sum [L];
  logic [N-1:0]   merged    [L];

  always_comb begin
    for (int k = 0; k < L; k++) begin
      slice_sum[k] = {1'b0, a_q[k][k*CHUNK +: CHUNK]}
                   + {1'b0, b_q[k][k*CHUNK +: CHUNK]}
                   + (CHUNK+1)'(c_q[k]);
      merged[k] = r_q[k];
      merged[k][k*CHUNK +: CHUNK] = slice_sum[k][CHUNK-1:0];
    end
  end

  logic         cin0;
  logic [N-1:0] b_eff;
  assign cin0  = (op == OP_SUB) || (((op == OP_ADD) || (op == OP_SAT)) && ci);
  assign b_eff = (op == OP_SUB) ? ~B : B;

  // Last stage: raw carry and overflow come from the unsaturated sum.
  logic [N-1:0] sum_fin;
  logic         a_msb;
  logic         b_msb;
  logic         co_raw;
  logic         ovf_raw;
  logic [N-1:0] out_d;
  logic         co_d;
  logic         ovf_d;

  always_comb begin
    sum_fin = merged[L-1];
    a_msb   = a_q[L-1][N-1];
    b_msb   = b_q[L-1][N-1];
    co_raw  = slice_sum[L-1][CHUNK];
    ovf_raw = (a_msb == b_msb) && (sum_fin[N-1] != a_msb);
    out_d   = sum_fin;
    co_d    = co_raw;
    ovf_d   = ovf_raw;
    if (op_q[L-1] == OP_PASS) begin
      out_d = x_q[L-1];
      co_d  = 1'b0;
      ovf_d = 1'b0;
    end else if ((op_q[L-1] == OP_SAT) && ovf_raw) begin
      out_d = a_msb ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < L; k++) begin
        vld_q[k] <= 1'b0;
        op_q[k]  <= '0;
        x_q[k]   <= '0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        c_q[k]   <= 1'b0;
        r_q[k]   <= '0;
      end
      out_valid <= 1'b0;
      out       <= '0;
      co        <= 1'b0;
      ovf       <= 1'b0;
    end else if (!stall) begin
      vld_q[0] <= in_valid;
      op_q[0]  <= op;
      x_q[0]   <= X;
      a_q[0]   <= A;
      b_q[0]   <= b_eff;
      c_q[0]   <= cin0;
      r_q[0]   <= '0;
      for (int k = 1; k < L; k++) begin
        vld_q[k] <= vld_q[k-1];
        op_q[k]  <= op_q[k-1];
        x_q[k]   <= x_q[k-1];
        a_q[k]   <= a_q[k-1];
        b_q[k]   <= b_q[k-1];
        c_q[k]   <= slice_sum[k-1][CHUNK];
        r_q[k]   <= merged[k-1];
      end
      out_valid <= vld_q[L-1];
      out       <= out_d;
      co        <= co_d;
      ovf       <= ovf_d;
    end
  end

endmodule

// File: tb/tb_pipelined_addsub_unit.sv
// Directed bench for pipelined_addsub_unit (N=16, CHUNK=4): latency, arithmetic corners,
// stall behaviour under a fixed out_ready pattern, and reset with beats in flight.
module tb_pipelined_addsub_unit;

  localparam int N = 16;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_PASS = 2'b10;
  localparam logic [1:0] OP_SAT  = 2'b11;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         ci;
  logic [N-1:0] x;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out;
  logic         co;
  logic         ovf;

  pipelined_addsub_unit #(.N(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .A(a), .B(b), .ci(ci), .X(x),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .co(co), .ovf(ovf)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic [15:0] x;
    logic [17:0] res;  // {out, co, ovf}
  } vec_t;

  function automatic vec_t mk(logic [1:0] o, logic [15:0] av, logic [15:0] bv,
                              logic c, logic [15:0] xv, logic [17:0] r);
    vec_t v;
    v.op = o; v.a = av; v.b = bv; v.ci = c; v.x = xv; v.res = r;
    return v;
  endfunction

  // ---------------- scoreboard state ----------------
  int          n_cmp;
  int          n_fail;
  logic [17:0] exp_q[$];
  logic        stalled_prev;
  logic [17:0] held;
  logic        took;
  vec_t        idle;
  vec_t        spec_v[7];
  vec_t        stream_v[8];
  int          pat[8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic iv, input vec_t v, input logic ordy);
    in_valid  = iv;
    op        = v.op;
    a         = v.a;
    b         = v.b;
    ci        = v.ci;
    x         = v.x;
    out_ready = ordy;
    #1;
    check("in_ready", in_ready, !(out_valid && !out_ready));
    if (stalled_prev) check("held", {out_valid, out, co, ovf}, {1'b1, held});
    took = 1'b0;
    if (out_valid && out_ready) begin
      check("order", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("result", {out, co, ovf}, exp_q.pop_front());
    end
    if (iv && in_ready) begin
      exp_q.push_back(v.res);
      took = 1'b1;
    end
    stalled_prev = out_valid && !out_ready;
    held         = {out, co, ovf};
    @(posedge clk);
    #1;
  endtask

  task automatic run_single(input vec_t v);
    int lat;
    step(1'b1, v, 1'b1);
    check("accepted", took, 1);
    lat = 0;
    while (!out_valid && lat < 10) begin
      step(1'b0, idle, 1'b1);
      lat++;
    end
    check("latency", lat, 4);
    step(1'b0, idle, 1'b1);
    check("drained", exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int i;
    int cyc;
    n_cmp = 0;
    n_fail = 0;
    stalled_prev = 1'b0;
    held = '0;
    took = 1'b0;
    idle = mk(OP_ADD, 16'h0000, 16'h0000, 1'b0, 16'h0000, 18'h0);

    spec_v[0] = mk(OP_ADD,  16'hFFFF, 16'h0001, 1'b0, 16'h0000, {16'h0000, 1'b1, 1'b0});
    spec_v[1] = mk(OP_SUB,  16'h0003, 16'h0005, 1'b0, 16'h0000, {16'hFFFE, 1'b0, 1'b0});
    spec_v[2] = mk(OP_SUB,  16'h8000, 16'h0001, 1'b1, 16'h0000, {16'h7FFF, 1'b1, 1'b1});
    spec_v[3] = mk(OP_SAT,  16'h7FFF, 16'h0001, 1'b0, 16'h0000, {16'h7FFF, 1'b0, 1'b1});
    spec_v[4] = mk(OP_SAT,  16'h8000, 16'hFFFF, 1'b0, 16'h0000, {16'h8000, 1'b1, 1'b1});
    spec_v[5] = mk(OP_SAT,  16'h0010, 16'h0020, 1'b1, 16'h0000, {16'h0031, 1'b0, 1'b0});
    spec_v[6] = mk(OP_PASS, 16'hFFFF, 16'hFFFF, 1'b1, 16'hA5A5, {16'hA5A5, 1'b0, 1'b0});

    stream_v[0] = mk(OP_ADD,  16'h1234, 16'h1111, 1'b0, 16'h0000, {16'h2345, 1'b0, 1'b0});
    stream_v[1] = mk(OP_SUB,  16'h1000, 16'h0001, 1'b0, 16'h0000, {16'h0FFF, 1'b1, 1'b0});
    stream_v[2] = mk(OP_PASS, 16'h5555, 16'hAAAA, 1'b1, 16'hBEEF, {16'hBEEF, 1'b0, 1'b0});
    stream_v[3] = mk(OP_SAT,  16'h4000, 16'h4000, 1'b0, 16'h0000, {16'h7FFF, 1'b0, 1'b1});
    stream_v[4] = mk(OP_ADD,  16'h7FFF, 16'h0000, 1'b1, 16'h0000, {16'h8000, 1'b0, 1'b1});
    stream_v[5] = mk(OP_SUB,  16'h0000, 16'h0000, 1'b0, 16'h0000, {16'h0000, 1'b1, 1'b0});
    stream_v[6] = mk(OP_SAT,  16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, {16'hFFFE, 1'b1, 1'b0});
    stream_v[7] = mk(OP_ADD,  16'h00FF, 16'h0F01, 1'b0, 16'h0000, {16'h1000, 1'b0, 1'b0});

    pat = '{1, 0, 0, 1, 0, 1, 1, 1};

    // Reset state
    rst_n = 1'b0;
    in_valid = 1'b0; op = OP_ADD; a = '0; b = '0; ci = 1'b0; x = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_outputs", {out, co, ovf}, 0);
    check("rst_in_ready", in_ready, 1);

    // Arithmetic corners, one beat at a time, each with a latency check
    for (int k = 0; k < 7; k++) run_single(spec_v[k]);

    // Back-to-back stream with stalls from the out_ready pattern
    i = 0;
    cyc = 0;
    while ((i < 8 || exp_q.size() != 0) && cyc < 100) begin
      if (i < 8) step(1'b1, stream_v[i], pat[cyc % 8][0]);
      else       step(1'b0, idle, pat[cyc % 8][0]);
      if (took) i++;
      cyc++;
    end
    check("stream_done", (i == 8) && (exp_q.size() == 0), 1);

    // Reset with three beats in flight; in_valid held high across the reset edge
    for (int k = 0; k < 3; k++) step(1'b1, stream_v[k], 1'b1);
    in_valid = 1'b1;
    op = stream_v[3].op; a = stream_v[3].a; b = stream_v[3].b; x = stream_v[3].x;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    stalled_prev = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_outputs", {out, co, ovf}, 0);
    check("midrst_in_ready", in_ready, 1);
    repeat (6) step(1'b0, idle, 1'b1);
    run_single(mk(OP_PASS, 16'h0000, 16'h0000, 1'b0, 16'h1234, {16'h1234, 1'b0, 1'b0}));

    check("final_queue", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
